// File: rtl/gol_grid.sv
// Game-of-Life array engine: ROWS x COLS cells, configurable B/S rules,
// toroidal or dead edges, seed load, single-step and free-run with still-life halt.
module gol_grid #(
  parameter int          ROWS           = 8,
  parameter int          COLS           = 8,
  parameter int          WRAP           = 1,
  parameter logic [8:0]  BIRTH_MASK     = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK   = 9'b000001100,
  parameter int          GEN_W          = 16,
  parameter int          STOP_ON_STABLE = 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] loadData,
  input  logic                 step,
  input  logic                 run,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     generation,
  output logic                 stable,
  output logic                 extinct,
  output logic                 running
);

  localparam int N = ROWS * COLS;
  localparam bit STOP = (STOP_ON_STABLE != 0);
  localparam logic [15:0] BM = {7'd0, BIRTH_MASK};
  localparam logic [15:0] SM = {7'd0, SURVIVE_MASK};

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t st;
  state_t st_nx;

  logic [N-1:0] nxt;
  logic         same;
  logic         adv;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      logic [3:0] cnt;
      for (genvar k = 0; k < 8; k++) begin : g_nb
        // k walks the 3x3 ring, skipping the centre
        localparam int DR = (k < 3) ? -1 : (k < 5) ? 0 : 1;
        localparam int DC =
          (k == 0 || k == 3 || k == 5) ? -1 :
          (k == 1 || k == 6) ? 0 : 1;
        localparam int RR = r + DR;
        localparam int CC = c + DC;
        localparam bit IN =
          (RR >= 0) && (RR < ROWS) &&
          (CC >= 0) && (CC < COLS);
        localparam int RW = (RR + ROWS) % ROWS;
        localparam int CW = (CC + COLS) % COLS;
        if (IN || (WRAP != 0)) begin : g_on
          assign nb[k] = grid[RW*COLS+CW];
        end else begin : g_off
          assign nb[k] = 1'b0;
        end
      end
      assign cnt = 4'($countones(nb));
      assign nxt[r*COLS+c] =
        grid[r*COLS+c] ? SM[cnt] : BM[cnt];
    end
  end

  assign same    = (nxt == grid);
  assign extinct = ~|grid;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) st <= IDLE;
    else         st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (load) begin
      st_nx = IDLE;
    end else begin
      case (st)
        IDLE:    if (run) st_nx = (STOP && same) ? HALT : RUN;
        RUN: begin
          if (!run)             st_nx = IDLE;
          else if (STOP && same) st_nx = HALT;
        end
        HALT:    if (!run) st_nx = IDLE;
        default: st_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    adv     = 1'b0;
    running = (st == RUN);
    if (!load) begin
      case (st)
        IDLE:    adv = step | run;
        RUN:     adv = run;
        default: adv = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      grid       <= '0;
      generation <= '0;
      stable     <= 1'b0;
    end else if (load) begin
      grid       <= loadData;
      generation <= '0;
      stable     <= 1'b0;
    end else if (adv) begin
      grid   <= nxt;
      stable <= same;
      if (generation != '1)
        generation <= generation + 1'b1;
    end
  end

endmodule

// File: tb/tb_gol_grid.sv
// Bench for gol_grid: toroidal/halting and dead-edge/free-running instances
// driven in lockstep and compared against a cell-by-cell Life model.
module tb_gol_grid;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = 64;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] loadData = '0;
  logic         step = 1'b0;
  logic         run = 1'b0;

  logic [N-1:0] g_w, g_d;
  logic [15:0]  gen_w, gen_d;
  logic         st_w, st_d, ex_w, ex_d, rn_w, rn_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gol_grid u_wrap (
    .clk(clk), .resetN(resetN), .load(load), .loadData(loadData),
    .step(step), .run(run), .grid(g_w), .generation(gen_w),
    .stable(st_w), .extinct(ex_w), .running(rn_w)
  );

  gol_grid #(.WRAP(0), .STOP_ON_STABLE(0)) u_dead (
    .clk(clk), .resetN(resetN), .load(load), .loadData(loadData),
    .step(step), .run(run), .grid(g_d), .generation(gen_d),
    .stable(st_d), .extinct(ex_d), .running(rn_d)
  );

  // reference state: [0] = toroidal + halting, [1] = dead edge, no halt
  logic [N-1:0] mg[2];
  int           mgen[2];
  bit           mstab[2];
  int           mmode[2];   // 0 idle, 1 free-running, 2 halted

  function automatic int idx(input int r, input int c);
    return r * COLS + c;
  endfunction

  function automatic logic [N-1:0] life(input logic [N-1:0] g, input bit wrap);
    logic [N-1:0] o;
    o = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
            end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
              continue;
            end
            n += int'(g[idx(rr, cc)]);
          end
        if (g[idx(r, c)]) o[idx(r, c)] = (n == 2 || n == 3);
        else              o[idx(r, c)] = (n == 3);
      end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mg[i] = '0; mgen[i] = 0; mstab[i] = 1'b0; mmode[i] = 0;
    end
  endtask

  task automatic model_clock(input bit ld, input logic [N-1:0] d,
                             input bit s, input bit rn);
    for (int i = 0; i < 2; i++) begin
      bit halt_ok, go;
      logic [N-1:0] nx;
      halt_ok = (i == 0);
      nx = life(mg[i], i == 0);
      go = 1'b0;
      if (ld) begin
        mg[i] = d; mgen[i] = 0; mstab[i] = 1'b0; mmode[i] = 0;
        continue;
      end
      if (mmode[i] == 0) begin
        go = s || rn;
        if (rn) mmode[i] = 1;
      end else if (mmode[i] == 1) begin
        if (!rn) mmode[i] = 0;
        else     go = 1'b1;
      end else if (!rn) begin
        mmode[i] = 0;
      end
      if (go) begin
        mstab[i] = (nx == mg[i]);
        if (halt_ok && mstab[i] && mmode[i] == 1) mmode[i] = 2;
        mg[i] = nx;
        if (mgen[i] < 65535) mgen[i]++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      string p;
      p = $sformatf("%s/%s", tag, i == 0 ? "wrap" : "dead");
      chk({p, ".grid"}, i == 0 ? g_w : g_d, mg[i]);
      chk({p, ".gen"}, i == 0 ? 64'(gen_w) : 64'(gen_d), 64'(mgen[i]));
      chk({p, ".stable"}, i == 0 ? 64'(st_w) : 64'(st_d), 64'(mstab[i]));
      chk({p, ".extinct"}, i == 0 ? 64'(ex_w) : 64'(ex_d),
          64'(mg[i] == '0));
      chk({p, ".running"}, i == 0 ? 64'(rn_w) : 64'(rn_d),
          64'(mmode[i] == 1));
    end
  endtask

  task automatic cyc(input string tag, input bit ld, input logic [N-1:0] d,
                     input bit s, input bit rn);
    load = ld; loadData = d; step = s; run = rn;
    @(posedge clk);
    model_clock(ld, d, s, rn);
    #1;
    check_all(tag);
  endtask

  logic [N-1:0] pat, glider, blk, blink, vert, corners;

  initial begin
    model_reset();
    #2;
    check_all("reset");
    chk("reset.extinct_w", 64'(ex_w), 64'd1);
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;
    check_all("release");

    // blinker flips to vertical and back
    blink = '0; blink[idx(2,1)] = 1; blink[idx(2,2)] = 1; blink[idx(2,3)] = 1;
    vert  = '0; vert[idx(1,2)]  = 1; vert[idx(2,2)]  = 1; vert[idx(3,2)]  = 1;
    cyc("blink_ld", 1, blink, 0, 0);
    cyc("blink_s1", 0, '0, 1, 0);
    chk("blink.vert", g_d, vert);
    chk("blink.gen1", 64'(gen_d), 64'd1);
    cyc("blink_s2", 0, '0, 1, 0);
    chk("blink.back", g_w, blink);
    chk("blink.gen2", 64'(gen_w), 64'd2);

    // still-life block: halting instance stops, other keeps counting
    blk = '0; blk[idx(1,1)] = 1; blk[idx(1,2)] = 1;
    blk[idx(2,1)] = 1; blk[idx(2,2)] = 1;
    cyc("blk_ld", 1, blk, 0, 0);
    cyc("blk_r1", 0, '0, 0, 1);
    chk("blk.halt_run", 64'(rn_w), 64'd0);
    chk("blk.halt_stab", 64'(st_w), 64'd1);
    chk("blk.halt_gen", 64'(gen_w), 64'd1);
    cyc("blk_r2", 0, '0, 1, 1);
    chk("blk.halt_hold", 64'(gen_w), 64'd1);
    cyc("blk_r3", 0, '0, 0, 0);
    cyc("blk_idle", 0, '0, 0, 0);

    // glider returns home on the torus after 32 generations
    glider = '0; glider[idx(0,1)] = 1; glider[idx(1,2)] = 1;
    glider[idx(2,0)] = 1; glider[idx(2,1)] = 1; glider[idx(2,2)] = 1;
    cyc("gl_ld", 1, glider, 0, 0);
    for (int i = 0; i < 32; i++) cyc("gl_run", 0, '0, 0, 1);
    cyc("gl_stop", 0, '0, 0, 0);
    chk("glider.home", g_w, glider);
    chk("glider.gen", 64'(gen_w), 64'd32);

    // corner cells: birth at (7,7) only across the wrapped edges
    corners = '0; corners[idx(0,0)] = 1; corners[idx(0,7)] = 1;
    corners[idx(7,0)] = 1;
    cyc("cor_ld", 1, corners, 0, 0);
    cyc("cor_s", 0, '0, 1, 0);
    chk("corner.born", 64'(g_w[idx(7,7)]), 64'd1);
    chk("corner.dead_ext", 64'(ex_d), 64'd1);

    // load beats step in the same cycle
    cyc("ldstep", 1, glider, 1, 0);
    chk("ldstep.grid", g_w, glider);
    chk("ldstep.gen", 64'(gen_w), 64'd0);

    // load while running, run held: re-enters RUN next cycle
    cyc("lr_r1", 0, '0, 0, 1);
    cyc("lr_r2", 0, '0, 0, 1);
    cyc("lr_ld", 1, blink, 0, 1);
    cyc("lr_r3", 0, '0, 0, 1);
    cyc("lr_r4", 0, '0, 0, 1);

    // randomized soups with random step/run/load
    pat = {$urandom, $urandom};
    cyc("rnd_ld", 1, pat, 0, 0);
    run = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit ld, s, rn;
      ld = ($urandom_range(0, 24) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 7) == 0) ? ~run : run;
      pat = {$urandom, $urandom} & {$urandom, $urandom};
      cyc("rnd", ld, pat, s, rn);
    end

    // asynchronous reset mid-run
    cyc("ar_ld", 1, glider, 0, 0);
    cyc("ar_r1", 0, '0, 0, 1);
    cyc("ar_r2", 0, '0, 0, 1);
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.grid", g_w, 64'd0);
    run = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    cyc("post_rst", 0, '0, 0, 0);
    cyc("post_run", 0, '0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gol_grid.md
Name: gol_grid

Overview:
- Parametrised Game-of-Life engine: a ROWS x COLS array of cells advanced one generation per advance cycle.
- Generalises the single-cell block:
  - configurable birth/survive rules
  - toroidal or dead-border edges
  - pattern load
  - single-step and free-run modes with auto-halt on a still life
  - generation counter, stable and extinct status
- Sits under the display/host controller, which loads seed patterns and samples the grid bus.

Parameters:
ROWS, 8, number of grid rows (>=3)
COLS, 8, number of grid columns (>=3)
WRAP, 1, 1 = toroidal edges; 0 = out-of-grid neighbours count as dead
BIRTH_MASK, 9'b000001000, bit n set = dead cell with n live neighbours is born (B3)
SURVIVE_MASK, 9'b000001100, bit n set = live cell with n live neighbours survives (S23)
GEN_W, 16, generation counter width
STOP_ON_STABLE, 1, 1 = free-run halts when a generation produces no change

Ports:
clk  input  1  clock, rising edge
resetN  input  1  asynchronous active-low reset
load  input  1  load loadData into grid this cycle
loadData  input  ROWS*COLS  seed pattern; cell (r,c) at bit r*COLS+c
step  input  1  advance exactly one generation (honoured in IDLE only)
run  input  1  level; free-run, one generation per cycle
grid  output  ROWS*COLS  current cell states, same bit mapping
generation  output  GEN_W  generations advanced since last load/reset
stable  output  1  last advance produced next grid == current grid
extinct  output  1  no live cells
running  output  1  FSM in RUN

Behaviour:
- Reset (resetN low, async): grid=0, generation=0, stable=0, FSM=IDLE, running=0; extinct=1 (follows grid).
- Neighbour count: 0..8, held in 4 bits.
  - WRAP=1: row/column indices wrap modulo ROWS/COLS.
  - WRAP=0: out-of-range neighbours contribute 0.
- Next state per cell: alive ? SURVIVE_MASK[count] : BIRTH_MASK[count]. Computed combinationally from the grid register.
- Advance = this cycle's clock edge sets grid<=next, generation<=generation+1 (saturating at all-ones), stable<=(next==grid).
- Latency: an advance requested on cycle N is visible on grid after edge N.
- extinct = ~|grid (combinational from register).
- FSM states:
  - IDLE:
    - step=1 -> one advance, stay IDLE.
    - run=1 -> RUN. The first advance occurs on the transition edge.
  - RUN:
    - Advance every cycle while run=1.
    - run=0 -> IDLE, with no advance on that edge.
    - STOP_ON_STABLE=1 and an advance yields next==grid -> HALT. That advance still updates generation and sets stable=1.
  - HALT:
    - No advance.
    - run=0 -> IDLE.
    - step ignored.
- running=1 only in RUN.
- load has top priority, in every state:
  - grid<=loadData, generation<=0, stable<=0, FSM<=IDLE.
  - step/run that same cycle are ignored. A run still high afterwards re-enters RUN on the next cycle.
- step in RUN or HALT: ignored.
- Extinct grid in RUN: next==grid, so with STOP_ON_STABLE it halts after one advance. Without STOP_ON_STABLE it keeps counting generations.
- Reset asserted mid-run: immediate return to reset values. No advance on the release edge unless step/run is sampled high.

Test Plan:
- 5x5, WRAP=0: load blinker (row 2, cols 1-3), pulse step -> vertical col 2, rows 1-3; generation=1, stable=0. Second step -> original pattern, generation=2.
- 4x4: load 2x2 block at rows/cols 1-2, run=1, STOP_ON_STABLE=1 -> after 1 advance FSM=HALT, running=0, stable=1, generation=1, grid unchanged. Drop run -> IDLE.
- 8x8, WRAP=1: load glider, run 32 cycles then drop run -> grid equals initial glider, generation=32.
- WRAP=0 vs WRAP=1: live cells at (0,0),(0,7),(7,0). Single step -> (7,7) born only with WRAP=1; with WRAP=0 the grid goes extinct=1.
- Load and step asserted the same cycle -> grid=loadData, generation=0, no advance. Assert resetN=0 mid-RUN -> grid=0, generation=0, running=0 immediately, without waiting for a clock edge.
